// File: rtl/vga_timing_pkg.sv
// Shared XGA 1024x768@60 timing constants and small helpers for the
// video timing generator.
package vga_timing_pkg;

   localparam int XGA_H_ACTIVE = 1024;
   localparam int XGA_H_FP     = 24;
   localparam int XGA_H_SYNC   = 136;
   localparam int XGA_H_BP     = 160;
   localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

   localparam int XGA_V_ACTIVE = 768;
   localparam int XGA_V_FP     = 3;
   localparam int XGA_V_SYNC   = 6;
   localparam int XGA_V_BP     = 29;
   localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

   // Sync windows are half-open: [start, end).
   localparam int XGA_HS_START = XGA_H_ACTIVE + XGA_H_FP;
   localparam int XGA_HS_END   = XGA_HS_START + XGA_H_SYNC;
   localparam int XGA_VS_START = XGA_V_ACTIVE + XGA_V_FP;
   localparam int XGA_VS_END   = XGA_VS_START + XGA_V_SYNC;

   typedef logic [11:0] cnt_t;

   function automatic logic in_window(cnt_t v, int lo, int len);
      return (int'(v) >= lo) && (int'(v) < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// N-stage, W-bit shift register with async active-low reset to a per-bit
// value; N = 0 degenerates to a wire that still shows the reset value.
module sig_delay #(
   parameter int             N       = 2,
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (N == 0) begin : g_wire
         assign q = rst_n ? d : RST_VAL;
      end else begin : g_pipe
         logic [W-1:0] stage_q [N];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
            end else begin
               stage_q[0] <= d;
               for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q = stage_q[N-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running video timing generator: pixel/line counters, frame markers
// and sync/data-enable delayed to match the renderer's output pipeline.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = XGA_H_ACTIVE,
   parameter int   H_FP     = XGA_H_FP,
   parameter int   H_SYNC   = XGA_H_SYNC,
   parameter int   H_BP     = XGA_H_BP,
   parameter int   V_ACTIVE = XGA_V_ACTIVE,
   parameter int   V_FP     = XGA_V_FP,
   parameter int   V_SYNC   = XGA_V_SYNC,
   parameter int   V_BP     = XGA_V_BP,
   parameter logic SYNC_POL = 1'b0,
   parameter int   PIPE_DLY = 2
) (
   input  logic        i_clk_74M,
   input  logic        i_rst_n,
   output logic [11:0] o_hcnt,
   output logic [11:0] o_vcnt,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_sof,
   output logic        o_eof,
   output logic [15:0] o_frame_cnt
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;

   generate
      if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_pipe_dly
         $error("vga_timing_gen: PIPE_DLY must be in 0..7");
      end
   endgenerate

   cnt_t        hcnt_p0, vcnt_p0;
   cnt_t        hcnt_nxt, vcnt_nxt;
   logic [15:0] frame_q;
   logic        sof_q, eof_q;
   logic        h_last, v_last;

   assign h_last = (hcnt_p0 == cnt_t'(H_TOTAL - 1));
   assign v_last = (vcnt_p0 == cnt_t'(V_TOTAL - 1));

   always_comb begin
      hcnt_nxt = hcnt_p0 + cnt_t'(1);
      vcnt_nxt = vcnt_p0;
      if (h_last) begin
         hcnt_nxt = '0;
         vcnt_nxt = v_last ? cnt_t'(0) : vcnt_p0 + cnt_t'(1);
      end
   end

   // Stage 0: counters, plus sof/eof decoded from the next state so they
   // line up with the counter values they name.
   always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hcnt_p0 <= '0;
         vcnt_p0 <= '0;
         frame_q <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         hcnt_p0 <= hcnt_nxt;
         vcnt_p0 <= vcnt_nxt;
         if (h_last && v_last) frame_q <= frame_q + 16'd1;
         sof_q   <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
         eof_q   <= (hcnt_nxt == cnt_t'(H_TOTAL - 1)) &&
                    (vcnt_nxt == cnt_t'(V_ACTIVE - 1));
      end
   end

   logic       hs_act, vs_act, de_p0;
   logic [2:0] flags_p0, flags_dly;

   assign hs_act   = in_window(hcnt_p0, HS_START, H_SYNC);
   assign vs_act   = in_window(vcnt_p0, VS_START, V_SYNC);
   assign de_p0    = (hcnt_p0 < cnt_t'(H_ACTIVE)) && (vcnt_p0 < cnt_t'(V_ACTIVE));
   // Polarity goes in before the delay so every stage idles at !SYNC_POL.
   assign flags_p0 = {hs_act ? SYNC_POL : ~SYNC_POL,
                      vs_act ? SYNC_POL : ~SYNC_POL,
                      de_p0};

   // Stage 0 -> PIPE_DLY: align sync/de with the renderer's RGB output.
   sig_delay #(
      .N       (PIPE_DLY),
      .W       (3),
      .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
   ) u_flag_dly (
      .clk   (i_clk_74M),
      .rst_n (i_rst_n),
      .d     (flags_p0),
      .q     (flags_dly)
   );

   assign o_hcnt      = hcnt_p0;
   assign o_vcnt      = vcnt_p0;
   assign o_hsync     = flags_dly[2];
   assign o_vsync     = flags_dly[1];
   assign o_de        = flags_dly[0];
   assign o_sof       = sof_q;
   assign o_eof       = eof_q;
   assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: expected outputs come from an absolute-time model of
// the raster (cycle index since reset release), checked every cycle.
module tb_vga_timing_gen;

   typedef struct packed {
      int   ha, hfp, hs, hbp, va, vfp, vs, vbp, dly;
      logic pol;
   } cfg_t;

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        hs;
      logic        vs;
      logic        de;
      logic        sof;
      logic        eof;
      logic [15:0] fc;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
      obs_t x;
   } trio_t;

   localparam cfg_t CA = '{ha:10, hfp:2, hs:3, hbp:4, va:6, vfp:1, vs:2, vbp:2, dly:2, pol:1'b0};
   localparam cfg_t CB = '{ha:7, hfp:1, hs:2, hbp:3, va:4, vfp:2, vs:1, vbp:1, dly:0, pol:1'b1};
   localparam cfg_t CX = '{ha:1024, hfp:24, hs:136, hbp:160, va:768, vfp:3, vs:6, vbp:29, dly:2, pol:1'b0};

   localparam int NCYC      = 24000;
   localparam int FORCE_CYC = 3000;
   localparam int QUIET_CYC = 6000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [11:0] a_h, a_v, b_h, b_v, x_h, x_v;
   logic        a_hs, a_vs, a_de, a_sof, a_eof;
   logic        b_hs, b_vs, b_de, b_sof, b_eof;
   logic        x_hs, x_vs, x_de, x_sof, x_eof;
   logic [15:0] a_fc, b_fc, x_fc;

   vga_timing_gen #(
      .H_ACTIVE(CA.ha), .H_FP(CA.hfp), .H_SYNC(CA.hs), .H_BP(CA.hbp),
      .V_ACTIVE(CA.va), .V_FP(CA.vfp), .V_SYNC(CA.vs), .V_BP(CA.vbp),
      .SYNC_POL(CA.pol), .PIPE_DLY(CA.dly)
   ) dut_a (
      .i_clk_74M(clk), .i_rst_n(rst_n), .o_hcnt(a_h), .o_vcnt(a_v),
      .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_sof(a_sof),
      .o_eof(a_eof), .o_frame_cnt(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(CB.ha), .H_FP(CB.hfp), .H_SYNC(CB.hs), .H_BP(CB.hbp),
      .V_ACTIVE(CB.va), .V_FP(CB.vfp), .V_SYNC(CB.vs), .V_BP(CB.vbp),
      .SYNC_POL(CB.pol), .PIPE_DLY(CB.dly)
   ) dut_b (
      .i_clk_74M(clk), .i_rst_n(rst_n), .o_hcnt(b_h), .o_vcnt(b_v),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_sof(b_sof),
      .o_eof(b_eof), .o_frame_cnt(b_fc)
   );

   vga_timing_gen dut_x (
      .i_clk_74M(clk), .i_rst_n(rst_n), .o_hcnt(x_h), .o_vcnt(x_v),
      .o_hsync(x_hs), .o_vsync(x_vs), .o_de(x_de), .o_sof(x_sof),
      .o_eof(x_eof), .o_frame_cnt(x_fc)
   );

   obs_t act_a, act_b, act_x;
   assign act_a = {a_h, a_v, a_hs, a_vs, a_de, a_sof, a_eof, a_fc};
   assign act_b = {b_h, b_v, b_hs, b_vs, b_de, b_sof, b_eof, b_fc};
   assign act_x = {x_h, x_v, x_hs, x_vs, x_de, x_sof, x_eof, x_fc};

   int total = 0;
   int bad   = 0;
   trio_t sb[$];

   // Raster position at cycle t (t edges since release); flags describe
   // the position PIPE_DLY cycles earlier, or the idle level before that.
   function automatic obs_t model(cfg_t c, bit run, longint t, longint base);
      obs_t   e;
      longint ht, vt, td, hh, vv;
      e    = '0;
      e.hs = ~c.pol;
      e.vs = ~c.pol;
      if (!run) return e;
      ht    = c.ha + c.hfp + c.hs + c.hbp;
      vt    = c.va + c.vfp + c.vs + c.vbp;
      e.h   = 12'(t % ht);
      e.v   = 12'((t / ht) % vt);
      e.fc  = 16'(base + t / (ht * vt));
      e.sof = (t > 0) && (t % (ht * vt) == 0);
      e.eof = ((t % ht) == ht - 1) && (((t / ht) % vt) == c.va - 1);
      td = t - c.dly;
      if (td >= 0) begin
         hh   = td % ht;
         vv   = (td / ht) % vt;
         e.de = (hh < c.ha) && (vv < c.va);
         e.hs = (hh >= c.ha + c.hfp && hh < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
         e.vs = (vv >= c.va + c.vfp && vv < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
      end
      return e;
   endfunction

   task automatic cmp(string dn, string f, longint a, longint e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s.%s got=%0d want=%0d at %0t", dn, f, a, e, $time);
      end
   endtask

   task automatic check(string dn, obs_t a, obs_t e);
      cmp(dn, "hcnt",  a.h,   e.h);
      cmp(dn, "vcnt",  a.v,   e.v);
      cmp(dn, "hsync", a.hs,  e.hs);
      cmp(dn, "vsync", a.vs,  e.vs);
      cmp(dn, "de",    a.de,  e.de);
      cmp(dn, "sof",   a.sof, e.sof);
      cmp(dn, "eof",   a.eof, e.eof);
      cmp(dn, "frame", a.fc,  e.fc);
   endtask

   always @(negedge clk) begin : monitor
      trio_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check("a", act_a, e.a);
         check("b", act_b, e.b);
         check("x", act_x, e.x);
      end
   end

   initial begin : driver
      bit     run;
      bit     forced;
      longint t;
      longint base_a, base_b, base_x;
      int     rst_left;
      trio_t  e;
      rst_n    = 1'b0;
      run      = 1'b0;
      forced   = 1'b0;
      t        = 0;
      base_a   = 0;
      base_b   = 0;
      base_x   = 0;
      rst_left = 4;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         if (run) t++;
         #1;
         if (!run) begin
            if (rst_left > 0) rst_left--;
            if (rst_left == 0) begin
               rst_n  = 1'b1;
               run    = 1'b1;
               t      = 0;
               base_a = 0;
               base_b = 0;
               base_x = 0;
            end
         end else if (cyc > QUIET_CYC && $urandom_range(0, 2499) == 0) begin
            rst_n    = 1'b0;
            run      = 1'b0;
            rst_left = $urandom_range(1, 6);
         end
         if (run && !forced && cyc >= FORCE_CYC) begin
            force dut_a.frame_q = 16'hFFFF;
            force dut_b.frame_q = 16'hFFFF;
            #1;
            release dut_a.frame_q;
            release dut_b.frame_q;
            forced = 1'b1;
            base_a = 64'hFFFF - t / ((CA.ha + CA.hfp + CA.hs + CA.hbp) * (CA.va + CA.vfp + CA.vs + CA.vbp));
            base_b = 64'hFFFF - t / ((CB.ha + CB.hfp + CB.hs + CB.hbp) * (CB.va + CB.vfp + CB.vs + CB.vbp));
         end
         e.a = model(CA, run, t, base_a);
         e.b = model(CB, run, t, base_b);
         e.x = model(CX, run, t, base_x);
         sb.push_back(e);
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
